// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard inputs from
// ID/EX and the hold/flush/bubble controls returned to the pipeline registers.
interface hazard_stall_controller_if #(
  parameter int STAT_WIDTH = 32
);
  logic [4:0]            ID_rs1;
  logic [4:0]            ID_rs2;
  logic                  ID_Uses_rs1;
  logic                  ID_Uses_rs2;
  logic                  EX_Mem_Read;
  logic [4:0]            EX_WriteAddress;
  logic                  EX_Branch_Taken;
  logic                  EX_Div_Start;
  logic                  PC_Hold;
  logic                  IF_ID_Hold;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Bubble;
  logic                  ID_EX_Hold;
  logic                  EX_MEM_Bubble;
  logic                  Div_Busy;
  logic                  Div_Done;
  logic [STAT_WIDTH-1:0] Stall_Count;

  // Pipeline side: presents hazard information, consumes controls.
  modport master (
    output ID_rs1, ID_rs2, ID_Uses_rs1, ID_Uses_rs2,
           EX_Mem_Read, EX_WriteAddress, EX_Branch_Taken, EX_Div_Start,
    input  PC_Hold, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold,
           EX_MEM_Bubble, Div_Busy, Div_Done, Stall_Count
  );

  // Controller side.
  modport slave (
    input  ID_rs1, ID_rs2, ID_Uses_rs1, ID_Uses_rs2,
           EX_Mem_Read, EX_WriteAddress, EX_Branch_Taken, EX_Div_Start,
    output PC_Hold, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold,
           EX_MEM_Bubble, Div_Busy, Div_Done, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the IF/ID, ID/EX and EX/MEM registers: load-use
// bubbles, wrong-path flush on taken branch/jump, front-end freeze for DIV/REM,
// and a saturating count of PC-hold cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; branch > divide start > load-use priority
//   DIV_WAIT | divide occupying EX; front end frozen until counter hits 0
module hazard_stall_controller #(
  parameter int DIV_LATENCY = 34,
  parameter int STAT_WIDTH  = 32
) (
  input logic                       CLK,
  input logic                       Reset,
  hazard_stall_controller_if.slave  bus
);

  // Counter holds DIV_LATENCY-2 at most; keep at least one bit for latency 2.
  localparam int CW = (DIV_LATENCY <= 2) ? 1 : $clog2(DIV_LATENCY);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    DIV_WAIT = 2'b01
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_hold, if_id_hold, if_id_flush, id_ex_bubble, id_ex_hold;
  logic ex_mem_bubble, div_busy, div_done;
  logic load_use;

  assign load_use = bus.EX_Mem_Read && (bus.EX_WriteAddress != 5'd0) &&
                    ((bus.ID_Uses_rs1 && (bus.ID_rs1 == bus.EX_WriteAddress)) ||
                     (bus.ID_Uses_rs2 && (bus.ID_rs2 == bus.EX_WriteAddress)));

  // Next-state and control decode; everything forced quiet while Reset is high.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_bubble = 1'b0;
    div_busy      = 1'b0;
    div_done      = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        RUN: begin
          if (bus.EX_Branch_Taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (bus.EX_Div_Start) begin
            // First EX cycle of the divide; remaining freeze cycles are counted down.
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_d         = CW'(DIV_LATENCY - 2);
            state_d       = DIV_WAIT;
          end else if (load_use) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        DIV_WAIT: begin
          div_busy = 1'b1;
          if (cnt_q != '0) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt_q - CW'(1);
          end else begin
            // Result is valid; let it flow into EX/MEM.
            div_done = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
  end

  // State, divide counter and statistics registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PC_Hold       = pc_hold;
  assign bus.IF_ID_Hold    = if_id_hold;
  assign bus.IF_ID_Flush   = if_id_flush;
  assign bus.ID_EX_Bubble  = id_ex_bubble;
  assign bus.ID_EX_Hold    = id_ex_hold;
  assign bus.EX_MEM_Bubble = ex_mem_bubble;
  assign bus.Div_Busy      = div_busy;
  assign bus.Div_Done      = div_done;
  assign bus.Stall_Count   = stall_cnt_q;

endmodule
